// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer on the output.
// Optional macro IMM_GEN_ILLEGAL_CHECK_EN adds the out_err flag and its storage.
//   state | meaning
//   EMPTY | nothing held, out_valid=0, in_ready=1
//   ONE   | OUT holds an entry, in_ready=1
//   FULL  | OUT and SKID hold entries, in_ready=0
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state, state_nxt;
  logic [31:0]       imm32;
  logic              illegal;
  logic [XLEN-1:0]   imm_new;
  logic              accept, drain;
  logic              load_out, load_skid, move_skid;
  logic [XLEN-1:0]   skid_imm;
  logic [TAG_W-1:0]  skid_tag;
  logic              unused_opcode;

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  imm32 = {instr[31:12], 12'b0};
      3'b100:  imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: illegal = 1'b1;
    endcase
  end

  assign imm_new   = XLEN'($signed(imm32));
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready looks only at the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b1;
    else        in_ready <= (state_nxt != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_ext  <= '0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else begin
      if (load_out) begin
        imm_ext <= imm_new;
        out_tag <= in_tag;
      end else if (move_skid) begin
        imm_ext <= skid_imm;
        out_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_imm <= imm_new;
        skid_tag <= in_tag;
      end
    end
  end

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
  logic out_err_q, skid_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
      skid_err  <= 1'b0;
    end else begin
      if (load_out)       out_err_q <= illegal;
      else if (move_skid) out_err_q <= skid_err;
      if (load_skid)      skid_err  <= illegal;
    end
  end

  assign out_err = out_err_q;
`else
  logic unused_illegal;

  assign unused_illegal = illegal;
  assign out_err        = 1'b0;
`endif

endmodule
